// File: rtl/lfsr_scrambler_gen.sv
// Additive (frame-synchronous) LFSR scrambler/descrambler with valid/ready flow control.
// One output register stage; the keystream for a whole beat is unrolled combinationally.
module lfsr_scrambler_gen #(
   parameter int                      P_DATA_WIDTH   = 32,
   parameter int                      P_CHAR_WIDTH   = P_DATA_WIDTH / 8,
   parameter int                      P_LFSR_WIDTH   = 16,
   parameter logic [P_LFSR_WIDTH-1:0] P_TAPS         = 16'h8805,
   parameter logic [P_LFSR_WIDTH-1:0] P_INIT_SEED    = 16'h768d,
   parameter int                      P_RESEED_BEATS = 0,
   parameter bit                      P_CHAR_MASK_EN = 1'b0
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_en,
   input  logic                    i_sof,
   input  logic [P_DATA_WIDTH-1:0] i_data,
   input  logic [P_CHAR_WIDTH-1:0] i_char,
   input  logic                    i_valid,
   output logic                    o_ready,
   output logic [P_DATA_WIDTH-1:0] o_data,
   output logic [P_CHAR_WIDTH-1:0] o_char,
   output logic                    o_sof,
   output logic                    o_reseed,
   output logic                    o_valid,
   input  logic                    i_ready
);

   localparam int LW    = P_LFSR_WIDTH;
   localparam int DW    = P_DATA_WIDTH;
   localparam int EW    = LW + DW;
   localparam int CNT_W = $clog2(P_RESEED_BEATS + 2);
   localparam logic [CNT_W-1:0] RESEED_CNT = CNT_W'(P_RESEED_BEATS);
   // With periodic reseed disabled the counter simply parks at zero.
   localparam logic [CNT_W-1:0] CNT_ONE    = (P_RESEED_BEATS != 0) ? CNT_W'(1) : '0;

   // s[0..LW-1] = seed, s[n] = XOR of s[n-k] for every tap k.
   function automatic logic [EW-1:0] lfsr_extend(input logic [LW-1:0] seed);
      logic [EW-1:0] s;
      s         = '0;
      s[LW-1:0] = seed;
      for (int n = LW; n < EW; n++) begin
         for (int k = 1; k <= LW; k++) begin
            if (P_TAPS[k-1]) s[n] = s[n] ^ s[n-k];
         end
      end
      return s;
   endfunction

   logic [LW-1:0]    seed_q, seed_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             init_pend_q, init_pend_d;
   logic [DW-1:0]    data_q, data_d;
   logic [P_CHAR_WIDTH-1:0] char_q, char_d;
   logic             sof_q, sof_d;
   logic             reseed_q, reseed_d;
   logic             valid_q, valid_d;

   logic             acc;
   logic             expired;
   logic             use_init;
   logic [LW-1:0]    eff_seed;
   logic [EW-1:0]    ext;
   logic [DW-1:0]    keystream;

   assign o_ready  = ~valid_q | i_ready;
   assign o_data   = data_q;
   assign o_char   = char_q;
   assign o_sof    = sof_q;
   assign o_reseed = reseed_q;
   assign o_valid  = valid_q;

   always_comb begin
      acc       = i_valid & o_ready;
      expired   = (P_RESEED_BEATS != 0) && (cnt_q == RESEED_CNT);
      // init_pend_q covers both "just out of reset" and "last beat was bypassed".
      use_init  = i_sof | expired | init_pend_q;
      eff_seed  = use_init ? P_INIT_SEED : seed_q;
      ext       = lfsr_extend(eff_seed);
      keystream = ext[DW-1:0];
      for (int j = 0; j < P_CHAR_WIDTH; j++) begin
         if (P_CHAR_MASK_EN && i_char[j]) keystream[8*j +: 8] = '0;
      end

      seed_d      = seed_q;
      cnt_d       = cnt_q;
      init_pend_d = init_pend_q;
      data_d      = data_q;
      char_d      = char_q;
      sof_d       = sof_q;
      reseed_d    = reseed_q;
      valid_d     = valid_q & ~i_ready;

      if (acc) begin
         valid_d = 1'b1;
         char_d  = i_char;
         sof_d   = i_sof;
         if (i_en) begin
            data_d      = i_data ^ keystream;
            seed_d      = ext[EW-1:DW];
            reseed_d    = use_init;
            init_pend_d = 1'b0;
            if (use_init) cnt_d = CNT_ONE;
            else if (cnt_q != RESEED_CNT) cnt_d = cnt_q + 1'b1;
         end else begin
            data_d      = i_data;
            seed_d      = P_INIT_SEED;
            cnt_d       = '0;
            reseed_d    = 1'b0;
            init_pend_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         seed_q      <= P_INIT_SEED;
         cnt_q       <= '0;
         init_pend_q <= 1'b1;
         data_q      <= '0;
         char_q      <= '0;
         sof_q       <= 1'b0;
         reseed_q    <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         seed_q      <= seed_d;
         cnt_q       <= cnt_d;
         init_pend_q <= init_pend_d;
         data_q      <= data_d;
         char_q      <= char_d;
         sof_q       <= sof_d;
         reseed_q    <= reseed_d;
         valid_q     <= valid_d;
      end
   end

endmodule

// File: tb/tb_lfsr_scrambler_gen.sv
// Bench for lfsr_scrambler_gen: five instances (default, chained descrambler, periodic reseed,
// char mask, 64/58 generic) share one stimulus bus and are each tracked by a scoreboard.
module tb_lfsr_scrambler_gen;

   localparam int N = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        t_en, t_sof, t_valid, rdy;
   logic [63:0] t_data;
   logic [7:0]  t_char;

   logic dut_ready, dut_valid, dut_sof, dut_reseed;   logic [31:0] dut_data;  logic [3:0] dut_char;
   logic desc_ready, desc_valid, desc_sof, desc_reseed; logic [31:0] desc_data; logic [3:0] desc_char;
   logic rs_ready, rs_valid, rs_sof, rs_reseed;       logic [31:0] rs_data;   logic [3:0] rs_char;
   logic cm_ready, cm_valid, cm_sof, cm_reseed;       logic [31:0] cm_data;   logic [3:0] cm_char;
   logic g_ready, g_valid, g_sof, g_reseed;           logic [63:0] g_data;    logic [7:0] g_char;

   lfsr_scrambler_gen u_dut (
      .i_clk(clk), .i_rst(rst), .i_en(t_en), .i_sof(t_sof), .i_data(t_data[31:0]), .i_char(t_char[3:0]),
      .i_valid(t_valid), .o_ready(dut_ready), .o_data(dut_data), .o_char(dut_char), .o_sof(dut_sof),
      .o_reseed(dut_reseed), .o_valid(dut_valid), .i_ready(desc_ready));

   lfsr_scrambler_gen u_desc (
      .i_clk(clk), .i_rst(rst), .i_en(1'b1), .i_sof(dut_sof), .i_data(dut_data), .i_char(dut_char),
      .i_valid(dut_valid), .o_ready(desc_ready), .o_data(desc_data), .o_char(desc_char), .o_sof(desc_sof),
      .o_reseed(desc_reseed), .o_valid(desc_valid), .i_ready(rdy));

   lfsr_scrambler_gen #(.P_RESEED_BEATS(4)) u_rs (
      .i_clk(clk), .i_rst(rst), .i_en(t_en), .i_sof(t_sof), .i_data(t_data[31:0]), .i_char(t_char[3:0]),
      .i_valid(t_valid), .o_ready(rs_ready), .o_data(rs_data), .o_char(rs_char), .o_sof(rs_sof),
      .o_reseed(rs_reseed), .o_valid(rs_valid), .i_ready(rdy));

   lfsr_scrambler_gen #(.P_CHAR_MASK_EN(1'b1)) u_cm (
      .i_clk(clk), .i_rst(rst), .i_en(t_en), .i_sof(t_sof), .i_data(t_data[31:0]), .i_char(t_char[3:0]),
      .i_valid(t_valid), .o_ready(cm_ready), .o_data(cm_data), .o_char(cm_char), .o_sof(cm_sof),
      .o_reseed(cm_reseed), .o_valid(cm_valid), .i_ready(rdy));

   lfsr_scrambler_gen #(.P_DATA_WIDTH(64), .P_LFSR_WIDTH(58), .P_TAPS(58'h200_0040_0000_0000),
                        .P_INIT_SEED(58'h123_4567_89AB_CDEF)) u_g (
      .i_clk(clk), .i_rst(rst), .i_en(t_en), .i_sof(t_sof), .i_data(t_data), .i_char(t_char),
      .i_valid(t_valid), .o_ready(g_ready), .o_data(g_data), .o_char(g_char), .o_sof(g_sof),
      .o_reseed(g_reseed), .o_valid(g_valid), .i_ready(rdy));

   // Reference configuration per scoreboard id: 0 dut, 1 desc, 2 rs, 3 cm, 4 g.
   int          cfg_w   [N] = '{32, 32, 32, 32, 64};
   int          cfg_l   [N] = '{16, 16, 16, 16, 58};
   logic [63:0] cfg_taps[N] = '{64'h8805, 64'h8805, 64'h8805, 64'h8805, 64'h0200_0040_0000_0000};
   logic [63:0] cfg_init[N] = '{64'h768d, 64'h768d, 64'h768d, 64'h768d, 64'h0123_4567_89AB_CDEF};
   int          cfg_rb  [N] = '{0, 0, 4, 0, 0};
   bit          cfg_mask[N] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   typedef struct { logic [63:0] data; logic [7:0] ch; bit sof; bit rs; } exp_t;
   exp_t        q[N][$];
   logic [63:0] m_seed[N];
   int          m_cnt [N];
   bit          m_pend[N];
   int          n_acc [N] = '{0, 0, 0, 0, 0};

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endfunction

   // Bit-serial sequence generator straight from the recurrence definition.
   function automatic void ks_gen(input logic [63:0] seed, input int l, input int w, input logic [63:0] taps,
                                  output logic [63:0] ks, output logic [63:0] nseed);
      bit s[$];
      ks = '0;
      nseed = '0;
      for (int i = 0; i < l; i++) s.push_back(seed[i]);
      for (int n = l; n < l + w; n++) begin
         bit b;
         b = 1'b0;
         for (int k = 1; k <= l; k++) if (taps[k-1]) b ^= s[n-k];
         s.push_back(b);
      end
      for (int i = 0; i < w; i++) ks[i] = s[i];
      for (int i = 0; i < l; i++) nseed[i] = s[w+i];
   endfunction

   function automatic void model_reset(input int id);
      m_seed[id] = cfg_init[id];
      m_cnt[id]  = 0;
      m_pend[id] = 1'b1;
      q[id].delete();
   endfunction

   function automatic exp_t model_beat(input int id, input bit en, input bit sof, input logic [63:0] d,
                                       input logic [7:0] ch);
      exp_t e;
      logic [63:0] ks, ns;
      bit init;
      e.ch  = ch;
      e.sof = sof;
      init  = sof || m_pend[id] || (cfg_rb[id] != 0 && m_cnt[id] == cfg_rb[id]);
      if (!en) begin
         e.data = d;
         e.rs   = 1'b0;
         m_seed[id] = cfg_init[id];
         m_cnt[id]  = 0;
         m_pend[id] = 1'b1;
      end else begin
         ks_gen(init ? cfg_init[id] : m_seed[id], cfg_l[id], cfg_w[id], cfg_taps[id], ks, ns);
         if (cfg_mask[id])
            for (int j = 0; j < cfg_w[id] / 8; j++) if (ch[j]) ks[8*j +: 8] = 8'h00;
         e.data = d ^ ks;
         e.rs   = init;
         m_seed[id] = ns;
         m_cnt[id]  = init ? 1 : m_cnt[id] + 1;
         m_pend[id] = 1'b0;
      end
      return e;
   endfunction

   function automatic void sb_step(input int id, input bit ivalid, input bit en, input bit sof,
                                   input logic [63:0] d, input logic [7:0] ch, input bit iready,
                                   input logic oready, input logic ovalid, input logic [63:0] od,
                                   input logic [7:0] och, input logic osof, input logic ors);
      bit ev;
      if (rst) begin
         model_reset(id);
         chk($sformatf("sb%0d valid in reset", id), 64'(ovalid), 64'(0));
         return;
      end
      ev = q[id].size() != 0;
      chk($sformatf("sb%0d o_valid", id), 64'(ovalid), 64'(ev));
      chk($sformatf("sb%0d o_ready", id), 64'(oready), 64'(!ev || iready));
      if (ev) begin
         chk($sformatf("sb%0d o_data", id), od, q[id][0].data);
         chk($sformatf("sb%0d o_char", id), 64'(och), 64'(q[id][0].ch));
         chk($sformatf("sb%0d o_sof", id), 64'(osof), 64'(q[id][0].sof));
         chk($sformatf("sb%0d o_reseed", id), 64'(ors), 64'(q[id][0].rs));
         if (iready) void'(q[id].pop_front());
      end
      if (ivalid && (!ev || iready)) begin
         q[id].push_back(model_beat(id, en, sof, d, ch));
         n_acc[id]++;
      end
   endfunction

   bit          rt_on = 1'b0;
   logic [31:0] rt_sent[$];
   logic [31:0] rt_got[$];
   int          rt_cyc[$];

   always @(negedge clk) begin
      sb_step(0, t_valid, t_en, t_sof, {32'b0, t_data[31:0]}, {4'b0, t_char[3:0]}, desc_ready,
              dut_ready, dut_valid, {32'b0, dut_data}, {4'b0, dut_char}, dut_sof, dut_reseed);
      sb_step(1, dut_valid, 1'b1, dut_sof, {32'b0, dut_data}, {4'b0, dut_char}, rdy,
              desc_ready, desc_valid, {32'b0, desc_data}, {4'b0, desc_char}, desc_sof, desc_reseed);
      sb_step(2, t_valid, t_en, t_sof, {32'b0, t_data[31:0]}, {4'b0, t_char[3:0]}, rdy,
              rs_ready, rs_valid, {32'b0, rs_data}, {4'b0, rs_char}, rs_sof, rs_reseed);
      sb_step(3, t_valid, t_en, t_sof, {32'b0, t_data[31:0]}, {4'b0, t_char[3:0]}, rdy,
              cm_ready, cm_valid, {32'b0, cm_data}, {4'b0, cm_char}, cm_sof, cm_reseed);
      sb_step(4, t_valid, t_en, t_sof, t_data, t_char, rdy,
              g_ready, g_valid, g_data, g_char, g_sof, g_reseed);
      if (rt_on && desc_valid && rdy) begin
         rt_got.push_back(desc_data);
         rt_cyc.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct { bit en; bit sof; logic [31:0] data; logic [3:0] ch; logic [31:0] exp; bit rs; } tv_t;
   tv_t         tv[6];
   logic [63:0] ks0, n0, ks1, n1, kg, ng;
   logic [31:0] snap;
   logic [31:0] rs_d[10];
   logic        rs_r[10];

   initial begin
      t_en = 1'b0; t_sof = 1'b0; t_valid = 1'b0; rdy = 1'b1; t_data = '0; t_char = '0;

      ks_gen(64'h768d, 16, 32, 64'h8805, ks0, n0);
      ks_gen(n0, 16, 32, 64'h8805, ks1, n1);
      tv[0] = '{1'b1, 1'b1, 32'h0,        4'b0001, ks0[31:0] & 32'hFFFF_FF00,                  1'b1};
      tv[1] = '{1'b0, 1'b0, 32'hDEADBEEF, 4'b0000, 32'hDEADBEEF,                               1'b0};
      tv[2] = '{1'b1, 1'b0, 32'h12345678, 4'b0000, 32'h12345678 ^ ks0[31:0],                  1'b1};
      tv[3] = '{1'b1, 1'b0, 32'hA5A5A5A5, 4'b1010, 32'hA5A5A5A5 ^ (ks1[31:0] & 32'h00FF_00FF), 1'b0};
      tv[4] = '{1'b1, 1'b1, 32'hFFFFFFFF, 4'b1111, 32'hFFFFFFFF,                               1'b1};
      tv[5] = '{1'b1, 1'b0, 32'h0,        4'b0000, ks1[31:0],                                  1'b0};

      repeat (2) tick();
      chk("reset o_valid", 64'(dut_valid), 64'(0));
      chk("reset o_data", 64'(dut_data), 64'(0));
      chk("reset o_char", 64'(dut_char), 64'(0));
      chk("reset o_sof", 64'(dut_sof), 64'(0));
      chk("reset o_reseed", 64'(dut_reseed), 64'(0));
      rst = 1'b0;
      tick();

      // Single beat out of reset.
      t_valid = 1'b1; t_en = 1'b1; t_sof = 1'b1; t_data = '0; t_char = '0;
      tick();
      t_valid = 1'b0; t_sof = 1'b0;
      chk("t1 o_valid", 64'(dut_valid), 64'(1));
      chk("t1 o_data lo", 64'(dut_data[15:0]), 64'(16'h768d));
      chk("t1 o_data hi", 64'(dut_data[31:16]), 64'(ks0[31:16]));
      chk("t1 o_reseed", 64'(dut_reseed), 64'(1));
      repeat (3) tick();

      // Round trip through the chained pair.
      rt_on = 1'b1;
      for (int i = 0; i < 64; i++) begin
         t_valid = 1'b1; t_en = 1'b1; t_sof = (i == 0); t_data = {32'b0, $urandom}; t_char = '0;
         rt_sent.push_back(t_data[31:0]);
         chk("t2 input ready", 64'(dut_ready), 64'(1));
         tick();
      end
      t_valid = 1'b0; t_sof = 1'b0;
      repeat (4) tick();
      rt_on = 1'b0;
      chk("t2 beat count", 64'(rt_got.size()), 64'(64));
      for (int i = 0; i < rt_got.size() && i < 64; i++)
         chk($sformatf("t2 round trip beat %0d", i), 64'(rt_got[i]), 64'(rt_sent[i]));
      if (rt_got.size() == 64) chk("t2 no bubbles", 64'(rt_cyc[63] - rt_cyc[0]), 64'(63));

      // Backpressure mid-stream.
      for (int i = 0; i < 20; i++) begin
         t_valid = 1'b1; t_en = 1'b1; t_sof = (i == 0); t_data = {$urandom, $urandom}; t_char = 8'($urandom);
         if (i == 10) begin
            rdy = 1'b0;
            #1;
            snap = dut_data;
            for (int c = 0; c < 5; c++) begin
               tick();
               chk("t3 o_data held", 64'(dut_data), 64'(snap));
               chk("t3 o_ready low", 64'(dut_ready), 64'(0));
            end
            rdy = 1'b1;
         end
         tick();
      end
      t_valid = 1'b0; t_sof = 1'b0;
      repeat (3) tick();

      // Periodic reseed every 4 beats.
      for (int i = 0; i < 10; i++) begin
         t_valid = 1'b1; t_en = 1'b1; t_sof = (i == 0); t_data = '0; t_char = '0;
         tick();
         rs_d[i] = rs_data;
         rs_r[i] = rs_reseed;
      end
      t_valid = 1'b0; t_sof = 1'b0;
      for (int i = 0; i < 10; i++)
         chk($sformatf("t4 reseed beat %0d", i), 64'(rs_r[i]), 64'(i % 4 == 0));
      chk("t4 keystream beat 0", 64'(rs_d[0]), 64'(ks0[31:0]));
      chk("t4 keystream beat 4", 64'(rs_d[4]), 64'(ks0[31:0]));
      chk("t4 keystream beat 8", 64'(rs_d[8]), 64'(ks0[31:0]));
      repeat (2) tick();

      // Char mask and bypass table.
      for (int i = 0; i < 6; i++) begin
         t_valid = 1'b1; t_en = tv[i].en; t_sof = tv[i].sof;
         t_data = {32'b0, tv[i].data}; t_char = {4'b0, tv[i].ch};
         tick();
         chk($sformatf("t5 row %0d o_valid", i), 64'(cm_valid), 64'(1));
         chk($sformatf("t5 row %0d o_data", i), 64'(cm_data), 64'(tv[i].exp));
         chk($sformatf("t5 row %0d o_reseed", i), 64'(cm_reseed), 64'(tv[i].rs));
      end
      t_valid = 1'b0; t_sof = 1'b0;
      repeat (2) tick();

      // Random traffic on all instances with a reset in the middle.
      ks_gen(64'h0123_4567_89AB_CDEF, 58, 64, 64'h0200_0040_0000_0000, kg, ng);
      for (int c = 0; c < 400; c++) begin
         t_valid = ($urandom % 4) != 0;
         t_en    = ($urandom % 8) != 0;
         t_sof   = (($urandom % 16) == 0) || (c == 0);
         t_data  = {$urandom, $urandom};
         t_char  = 8'($urandom);
         rdy     = ($urandom % 4) != 0;
         if (c == 200) begin
            rst = 1'b1;
            #1;
            chk("mid reset dut o_valid", 64'(dut_valid), 64'(0));
            chk("mid reset g o_valid", 64'(g_valid), 64'(0));
         end
         if (c == 202) begin
            rst = 1'b0; t_valid = 1'b1; t_en = 1'b1; t_sof = 1'b0; t_data = '0; rdy = 1'b1;
         end
         tick();
         if (c == 202) begin
            chk("post reset g o_reseed", 64'(g_reseed), 64'(1));
            chk("post reset g o_data", g_data, kg);
            chk("post reset dut o_data", 64'(dut_data), 64'(ks0[31:0]));
         end
      end
      t_valid = 1'b0; rdy = 1'b1;
      repeat (3) tick();
      chk("t6 generic beats >= 100", 64'(n_acc[4] >= 100), 64'(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lfsr_scrambler_gen.md
# lfsr_scrambler_gen

- Parametrised additive (frame-synchronous) LFSR scrambler/descrambler for the 64B66B/8b10b PHY datapaths.
- Generalises the fixed 32-bit/16-bit-LFSR data scrambler in four ways:
  - configurable data width, LFSR length and tap polynomial;
  - valid/ready handshake with backpressure;
  - start-of-frame and periodic reseeding;
  - optional pass-through of control-character bytes.
- The same block instance scrambles on TX and descrambles on RX, because additive scrambling is self-inverse when both ends are seeded identically.

## Interface

**Parameters**

- P_DATA_WIDTH, 32: data beat width in bits; must be a multiple of 8.
- P_CHAR_WIDTH, P_DATA_WIDTH/8: one char flag per byte.
- P_LFSR_WIDTH, 16: LFSR length L.
- P_TAPS, 16'h8805: tap mask. Bit k-1 set means the term s[n-k] is in the recurrence. The default gives s[n]=s[n-16]^s[n-12]^s[n-3]^s[n-1].
- P_INIT_SEED, 16'h768d: reload value, L bits.
- P_RESEED_BEATS, 0: force a reload after this many scrambled beats; 0 disables.
- P_CHAR_MASK_EN, 0: when 1, bytes whose i_char bit is set pass unscrambled.

**Ports**

- Clock and reset (already decided): reset i_rst, asynchronous, active-high; clock i_clk.
- i_clk, input, 1: clock.
- i_rst, input, 1: asynchronous active-high reset.
- i_en, input, 1: scramble enable, sampled with each accepted beat.
- i_sof, input, 1: start of frame, qualified by i_valid.
- i_data, input, P_DATA_WIDTH: input beat.
- i_char, input, P_CHAR_WIDTH: control-character flags.
- i_valid, input, 1: input beat valid.
- o_ready, output, 1: block can accept a beat.
- o_data, output, P_DATA_WIDTH: scrambled (or bypassed) beat.
- o_char, output, P_CHAR_WIDTH: i_char delayed.
- o_sof, output, 1: i_sof delayed.
- o_reseed, output, 1: this output beat was scrambled from P_INIT_SEED.
- o_valid, output, 1: output beat valid.
- i_ready, input, 1: downstream accepts the output beat.

## Operation

**Keystream**
- Build the extended sequence s[0..L+W-1], with W = P_DATA_WIDTH:
  - s[0..L-1] = seed register;
  - s[n] = XOR of s[n-k] over every k with P_TAPS[k-1]=1.
- Keystream for the beat = s[0..W-1]. Next seed = s[W..W+L-1].
- The extended sequence is pure combinational unrolling; there is one register stage in total.

**Acceptance**
- A beat is accepted when acc = i_valid & o_ready.
- The seed and reseed counter change only on accepted beats. Idle and stalled cycles freeze them.

**Seed selection (effective seed) for an accepted beat**
- P_INIT_SEED if any of these hold:
  - i_sof=1;
  - the reseed counter has reached P_RESEED_BEATS (only when P_RESEED_BEATS≠0);
  - the previous accepted beat had i_en=0 (the seed register already holds init in that case).
- Otherwise the seed register.

**Data path for an accepted beat with i_en=1**
- o_data = i_data ^ keystream.
- If P_CHAR_MASK_EN=1, every byte j with i_char[j]=1 is copied unscrambled. The LFSR still advances by a full W bits.
- The seed register loads the next seed computed from the effective seed.
- The counter is set to 1 if the effective seed was init, otherwise it increments.
- o_reseed = 1 if the effective seed was init.

**Data path for an accepted beat with i_en=0**
- o_data = i_data.
- The seed register loads P_INIT_SEED.
- The counter clears to 0.
- o_reseed = 0.

**Sideband**
- o_char and o_sof always copy i_char and i_sof for the accepted beat.

**Simultaneous events**
- i_sof together with counter expiry produces a single reload. The counter restarts at 1.

## Timing

- Reset values:
  - o_valid=0, o_data=0, o_char=0, o_sof=0, o_reseed=0;
  - seed = P_INIT_SEED, counter = 0.
- o_ready = ~o_valid | i_ready, combinational. This gives full throughput with one output register.
- Latency is 1 cycle: a beat accepted at edge N appears on the outputs after edge N with o_valid=1.
- Backpressure: while o_valid=1 and i_ready=0, all outputs hold stable, o_ready=0, and the seed and counter are frozen.
- o_valid clears after an edge where i_ready=1 and no new beat is accepted.
- Reset asserted mid-stream:
  - any in-flight output beat is dropped (o_valid=0);
  - the next beat after reset uses P_INIT_SEED, even if i_sof=0.
- The counter saturates at P_RESEED_BEATS and never wraps.

## Test plan

1. **Reset, single beat.** Reset, then one beat with i_en=1, i_sof=1, i_data=0, i_char=0.
   - One cycle later: o_valid=1, o_data[15:0]=16'h768d, o_reseed=1.
   - o_data[31:16] matches the software LFSR model.
2. **Round trip.** 64 back-to-back random beats through two chained instances (scrambler, then descrambler), with i_sof on beat 0 and i_en=1.
   - Second instance output equals the original data, beat for beat.
   - One beat per cycle, no bubbles.
3. **Backpressure.** Hold i_ready=0 for 5 cycles mid-stream.
   - o_data is stable and o_ready=0 throughout.
   - After release, the stream continues with keystream identical to the no-stall run.
4. **Periodic reseed.** P_RESEED_BEATS=4, 10 beats, i_sof only on beat 0.
   - o_reseed=1 on beats 0, 4 and 8.
   - Beats 4 and 8 carry the same keystream as beat 0.
5. **Char mask and bypass.** P_CHAR_MASK_EN=1, i_char=4'b0001, i_data=0.
   - o_data[7:0]=0; the other bytes are scrambled.
   - Next beat with i_en=0 and i_data=32'hDEADBEEF: o_data=32'hDEADBEEF.
   - The following beat with i_en=1 has o_reseed=1.
6. **Generic configuration.** P_DATA_WIDTH=64, P_LFSR_WIDTH=58, P_TAPS with bits 57 and 38 set (x^58+x^39+1), 100 random beats.
   - Output matches the bit-serial software model.
